cbus_arbiter: RTL and testbench

CBUS_ARBITER -- requirements
Module: cbus_arbiter

---
 rtl/cbus_arbiter.sv | 146 ++++++++++++++
 tb/tb_cbus_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_arbiter.sv
// Two-port cbus arbiter: picks one requester (fixed priority or round-robin)
// and holds that grant for a whole burst until the downstream returns its last beat.
module cbus_arbiter #(
  parameter int unsigned ROUND_ROBIN = 0,
  localparam int unsigned AW = 64,
  localparam int unsigned DW = 64,
  localparam int unsigned SW = 8,
  localparam int unsigned ZW = 3,
  localparam int unsigned LW = 8,
  localparam int unsigned BW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_valid,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_data,
  input  logic [SW-1:0] m0_strobe,
  input  logic [ZW-1:0] m0_size,
  input  logic [LW-1:0] m0_len,
  input  logic [BW-1:0] m0_burst,
  output logic          m0_ready,
  output logic          m0_last,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_valid,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_data,
  input  logic [SW-1:0] m1_strobe,
  input  logic [ZW-1:0] m1_size,
  input  logic [LW-1:0] m1_len,
  input  logic [BW-1:0] m1_burst,
  output logic          m1_ready,
  output logic          m1_last,
  output logic [DW-1:0] m1_rdata,
  output logic          oreq_valid,
  output logic [AW-1:0] oreq_addr,
  output logic [DW-1:0] oreq_data,
  output logic [SW-1:0] oreq_strobe,
  output logic [ZW-1:0] oreq_size,
  output logic [LW-1:0] oreq_len,
  output logic [BW-1:0] oreq_burst,
  input  logic          oresp_ready,
  input  logic          oresp_last,
  input  logic [DW-1:0] oresp_data
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0] state, state_next;
  logic       grant, grant_next;
  logic       prev, prev_next;
  logic       busy;

  // prev resets to 1 so port 0 wins the first round-robin tie
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= 1'b0;
      prev  <= 1'b1;
    end else begin
      state <= state_next;
      grant <= grant_next;
      prev  <= prev_next;
    end
  end

  always_comb begin
    state_next = state;
    grant_next = grant;
    prev_next  = prev;
    case (state)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          state_next = BUSY;
          if (m0_valid && m1_valid) begin
            grant_next = (ROUND_ROBIN != 0) ? ~prev : 1'b0;
          end else begin
            grant_next = m1_valid;
          end
        end
      end
      BUSY: begin
        // Only the final accepted beat releases the bus; valid drops are ignored
        if (oresp_ready && oresp_last) begin
          state_next = IDLE;
          prev_next  = grant;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == BUSY);

  // Request mux depends only on registered state and requester fields
  always_comb begin
    oreq_valid  = 1'b0;
    oreq_addr   = '0;
    oreq_data   = '0;
    oreq_strobe = '0;
    oreq_size   = '0;
    oreq_len    = '0;
    oreq_burst  = '0;
    if (busy) begin
      if (grant) begin
        oreq_valid  = m1_valid;
        oreq_addr   = m1_addr;
        oreq_data   = m1_data;
        oreq_strobe = m1_strobe;
        oreq_size   = m1_size;
        oreq_len    = m1_len;
        oreq_burst  = m1_burst;
      end else begin
        oreq_valid  = m0_valid;
        oreq_addr   = m0_addr;
        oreq_data   = m0_data;
        oreq_strobe = m0_strobe;
        oreq_size   = m0_size;
        oreq_len    = m0_len;
        oreq_burst  = m0_burst;
      end
    end
  end

  // Response demux: only the granted port sees the downstream response
  always_comb begin
    m0_ready = 1'b0;
    m0_last  = 1'b0;
    m0_rdata = '0;
    m1_ready = 1'b0;
    m1_last  = 1'b0;
    m1_rdata = '0;
    if (busy) begin
      if (grant) begin
        m1_ready = oresp_ready;
        m1_last  = oresp_last;
        m1_rdata = oresp_data;
      end else begin
        m0_ready = oresp_ready;
        m0_last  = oresp_last;
        m0_rdata = oresp_data;
      end
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: fixed-priority (inst 0) and round-robin (inst 1) copies
// share stimulus; a transaction-level model is compared every cycle plus literal checks.
module tb_cbus_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        mv[2];
  logic [63:0] maddr[2];
  logic [63:0] mdata[2];
  logic [7:0]  mstrb[2];
  logic [2:0]  msize[2];
  logic [7:0]  mlen[2];
  logic [1:0]  mburst[2];
  logic        oresp_ready, oresp_last;
  logic [63:0] oresp_data;

  logic        ov[2];
  logic [63:0] oa[2];
  logic [63:0] od[2];
  logic [7:0]  os[2];
  logic [2:0]  oz[2];
  logic [7:0]  ol[2];
  logic [1:0]  ob[2];
  logic        rr[2][2];
  logic        rl[2][2];
  logic [63:0] rd[2][2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    cbus_arbiter #(.ROUND_ROBIN(k)) dut (
      .clk(clk), .reset(reset),
      .m0_valid(mv[0]), .m0_addr(maddr[0]), .m0_data(mdata[0]), .m0_strobe(mstrb[0]),
      .m0_size(msize[0]), .m0_len(mlen[0]), .m0_burst(mburst[0]),
      .m0_ready(rr[k][0]), .m0_last(rl[k][0]), .m0_rdata(rd[k][0]),
      .m1_valid(mv[1]), .m1_addr(maddr[1]), .m1_data(mdata[1]), .m1_strobe(mstrb[1]),
      .m1_size(msize[1]), .m1_len(mlen[1]), .m1_burst(mburst[1]),
      .m1_ready(rr[k][1]), .m1_last(rl[k][1]), .m1_rdata(rd[k][1]),
      .oreq_valid(ov[k]), .oreq_addr(oa[k]), .oreq_data(od[k]), .oreq_strobe(os[k]),
      .oreq_size(oz[k]), .oreq_len(ol[k]), .oreq_burst(ob[k]),
      .oresp_ready(oresp_ready), .oresp_last(oresp_last), .oresp_data(oresp_data)
    );
  end

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the bus, and who was served last
  bit busy_m[2];
  bit owner_m[2];
  bit last_m[2];

  function automatic bit pick(input int k, input bit last_served);
    if (mv[0] && mv[1]) return (k == 1) ? !last_served : 1'b0;
    return mv[1];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        busy_m[k]  <= 1'b0;
        owner_m[k] <= 1'b0;
        last_m[k]  <= 1'b1;
      end else if (!busy_m[k] && (mv[0] || mv[1])) begin
        busy_m[k]  <= 1'b1;
        owner_m[k] <= pick(k, last_m[k]);
      end else if (busy_m[k] && oresp_ready && oresp_last) begin
        busy_m[k] <= 1'b0;
        last_m[k] <= owner_m[k];
      end
    end
  end

  logic [149:0] exp_o, act_o;
  logic [131:0] exp_r, act_r;
  bit           own0, own1;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        exp_o = '0;
        if (busy_m[k])
          exp_o = {mv[owner_m[k]], maddr[owner_m[k]], mdata[owner_m[k]], mstrb[owner_m[k]],
                   msize[owner_m[k]], mlen[owner_m[k]], mburst[owner_m[k]]};
        act_o = {ov[k], oa[k], od[k], os[k], oz[k], ol[k], ob[k]};
        own1 = busy_m[k] && owner_m[k];
        own0 = busy_m[k] && !owner_m[k];
        exp_r = {own1 && oresp_ready, own1 && oresp_last, own1 ? oresp_data : 64'h0,
                 own0 && oresp_ready, own0 && oresp_last, own0 ? oresp_data : 64'h0};
        act_r = {rr[k][1], rl[k][1], rd[k][1], rr[k][0], rl[k][0], rd[k][0]};
        chk($sformatf("cyc_oreq_i%0d", k), 160'(act_o), 160'(exp_o));
        chk($sformatf("cyc_resp_i%0d", k), 160'(act_r), 160'(exp_r));
      end
    end
  end

  // Which port the round-robin copy actually served, in order
  int log_q[$];
  bit log_en = 1'b0;
  always @(negedge clk) begin
    if (log_en) begin
      for (int p = 0; p < 2; p++)
        if (rr[1][p] && rl[1][p]) log_q.push_back(p);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int p = 0; p < 2; p++) begin
      mv[p] = 1'b0; maddr[p] = '0; mdata[p] = '0; mstrb[p] = '0;
      msize[p] = '0; mlen[p] = '0; mburst[p] = '0;
    end
    oresp_ready = 1'b0; oresp_last = 1'b0; oresp_data = '0;
  endtask

  int exp_order[4] = '{0, 1, 0, 1};

  initial begin
    clear_inputs();
    reset = 1'b1;
    cyc();
    chk_en = 1'b1;
    #1;
    chk("rst_oreq_valid_fp", 160'(ov[0]), 160'(1'b0));
    chk("rst_oreq_valid_rr", 160'(ov[1]), 160'(1'b0));
    chk("rst_m0_ready", 160'(rr[0][0]), 160'(1'b0));
    chk("rst_m1_rdata", 160'(rd[0][1]), 160'(64'h0));
    reset = 1'b0;
    cyc();

    // Single read on port 1
    mv[1] = 1'b1; maddr[1] = 64'h8000_0000; #1;
    chk("read_latency_idle", 160'(ov[0]), 160'(1'b0));
    cyc(); #1;
    chk("read_oreq_valid", 160'(ov[0]), 160'(1'b1));
    chk("read_oreq_addr", 160'(oa[0]), 160'(64'h8000_0000));
    oresp_ready = 1'b1; oresp_last = 1'b1; oresp_data = 64'hDEAD_BEEF; #1;
    chk("read_m1_rdata", 160'(rd[0][1]), 160'(64'hDEAD_BEEF));
    chk("read_m1_last", 160'(rl[0][1]), 160'(1'b1));
    chk("read_m0_ready", 160'(rr[0][0]), 160'(1'b0));
    cyc(); clear_inputs(); #1;
    chk("read_back_idle", 160'(ov[0]), 160'(1'b0));
    cyc();

    // Fixed-priority tie
    mv[0] = 1'b1; maddr[0] = 64'h1000; mv[1] = 1'b1; maddr[1] = 64'h2000;
    cyc(); #1;
    chk("tie_first_addr", 160'(oa[0]), 160'(64'h1000));
    oresp_ready = 1'b1; oresp_last = 1'b1; #1;
    chk("tie_m0_ready", 160'(rr[0][0]), 160'(1'b1));
    chk("tie_m1_ready", 160'(rr[0][1]), 160'(1'b0));
    cyc(); mv[0] = 1'b0; oresp_ready = 1'b0; oresp_last = 1'b0; #1;
    chk("tie_gap_idle", 160'(ov[0]), 160'(1'b0));
    cyc(); #1;
    chk("tie_second_valid", 160'(ov[0]), 160'(1'b1));
    chk("tie_second_addr", 160'(oa[0]), 160'(64'h2000));
    oresp_ready = 1'b1; oresp_last = 1'b1;
    cyc(); clear_inputs(); cyc();

    // Round-robin alternation with both held valid
    mv[0] = 1'b1; mv[1] = 1'b1; oresp_ready = 1'b1; oresp_last = 1'b1;
    log_q.delete(); log_en = 1'b1;
    repeat (8) cyc();
    log_en = 1'b0;
    chk("rr_count", 160'(log_q.size()), 160'(4));
    for (int i = 0; i < 4 && i < log_q.size(); i++)
      chk($sformatf("rr_order_%0d", i), 160'(log_q[i]), 160'(exp_order[i]));
    clear_inputs(); cyc();

    // Burst lock: 4 beats to port 0 while port 1 waits
    mv[0] = 1'b1; mlen[0] = 8'd3; maddr[0] = 64'h3000; mv[1] = 1'b1; maddr[1] = 64'h4000;
    cyc(); #1;
    chk("burst_grant_fp", 160'(oa[0]), 160'(64'h3000));
    chk("burst_grant_rr", 160'(oa[1]), 160'(64'h3000));
    for (int b = 0; b < 4; b++) begin
      oresp_ready = 1'b1; oresp_last = (b == 3); oresp_data = 64'hB0 + 64'(b); #1;
      chk($sformatf("burst_m0_ready_%0d", b), 160'(rr[0][0]), 160'(1'b1));
      chk($sformatf("burst_m1_ready_%0d", b), 160'(rr[0][1]), 160'(1'b0));
      chk($sformatf("burst_rdata_%0d", b), 160'(rd[0][0]), 160'(64'hB0 + 64'(b)));
      cyc();
      if (b == 1) begin
        oresp_ready = 1'b0; oresp_last = 1'b0; mv[0] = 1'b0; #1;
        chk("burst_drop_valid", 160'(ov[0]), 160'(1'b0));
        chk("burst_drop_m1", 160'(rr[0][1]), 160'(1'b0));
        cyc();
        mv[0] = 1'b1;
      end
    end
    mv[0] = 1'b0; oresp_ready = 1'b0; oresp_last = 1'b0; #1;
    chk("burst_gap_idle", 160'(ov[0]), 160'(1'b0));
    cyc(); #1;
    chk("burst_m1_granted_fp", 160'(oa[0]), 160'(64'h4000));
    chk("burst_m1_granted_rr", 160'(oa[1]), 160'(64'h4000));
    oresp_ready = 1'b1; oresp_last = 1'b1;
    cyc(); clear_inputs(); cyc();

    // Write with a 3-cycle downstream stall
    mv[0] = 1'b1; mstrb[0] = 8'hFF; mdata[0] = 64'h1122_3344_5566_7788;
    msize[0] = 3'd3; mburst[0] = 2'd1; maddr[0] = 64'h7000;
    cyc();
    for (int s = 0; s < 3; s++) begin
      #1;
      chk($sformatf("wr_valid_%0d", s), 160'(ov[0]), 160'(1'b1));
      chk($sformatf("wr_strobe_%0d", s), 160'(os[0]), 160'(8'hFF));
      chk($sformatf("wr_data_%0d", s), 160'(od[0]), 160'(64'h1122_3344_5566_7788));
      cyc();
    end
    oresp_ready = 1'b1; oresp_last = 1'b1; #1;
    chk("wr_m0_ready", 160'(rr[0][0]), 160'(1'b1));
    cyc(); clear_inputs(); cyc();

    // Reset in the middle of a 4-beat burst
    mv[0] = 1'b1; mlen[0] = 8'd3; maddr[0] = 64'h5000;
    cyc();
    oresp_ready = 1'b1;
    cyc();
    reset = 1'b1; #1;
    chk("mrst_beat2_routed", 160'(rr[0][0]), 160'(1'b1));
    cyc();
    reset = 1'b0; oresp_ready = 1'b0; #1;
    chk("mrst_idle_fp", 160'(ov[0]), 160'(1'b0));
    chk("mrst_idle_rr", 160'(ov[1]), 160'(1'b0));
    mv[1] = 1'b1; maddr[1] = 64'h6000;
    cyc(); #1;
    chk("mrst_rr_tie_port0", 160'(oa[1]), 160'(64'h5000));
    chk("mrst_fp_port0", 160'(oa[0]), 160'(64'h5000));
    oresp_ready = 1'b1; oresp_last = 1'b1; #1;
    chk("mrst_rr_m0_last", 160'(rl[1][0]), 160'(1'b1));
    chk("mrst_rr_m1_last", 160'(rl[1][1]), 160'(1'b0));
    cyc(); mv[0] = 1'b0; oresp_ready = 1'b0; oresp_last = 1'b0;
    cyc(); #1;
    chk("mrst_fresh_m1", 160'(oa[1]), 160'(64'h6000));
    oresp_ready = 1'b1; oresp_last = 1'b1;
    cyc(); clear_inputs(); cyc(); cyc();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
